// File: rtl/pc_fetch_sequencer.sv
// Next-PC controller for one core: sequences start-up, branch/jump redirects
// (including redirects held across ID stalls) and halt, and drives the hold
// input of the core's PC register. Also provides an IF flush strobe, a sticky
// misaligned-target flag and a saturating fetched-instruction counter.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [31:0] pc_cur,
    input  logic        ID_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        halt_req,
    output logic [31:0] next_pc,
    output logic        pc_hold,
    output logic        if_flush,
    output logic        fetch_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BOOT   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_PEND   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redir;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        target_bad;
    logic        count_en;

    // Redirect decode: branch wins over jump; target is forced word-aligned.
    always_comb begin
        redir      = br_taken | jmp_valid;
        raw_target = br_taken ? br_target : jmp_target;
        target     = {raw_target[31:2], 2'b00};
        target_bad = (raw_target[1:0] != 2'b00);
    end

    // FSM next-state and combinational PC-control outputs.
    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        misalign_d  = misalign_q;
        next_pc     = pc_cur;
        pc_hold     = 1'b1;
        if_flush    = 1'b0;
        fetch_valid = 1'b0;
        count_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                next_pc = RESET_PC;
                if (start) begin
                    state_d = S_BOOT;
                end
            end
            S_BOOT: begin
                next_pc = RESET_PC;
                pc_hold = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (ID_stall) begin
                    if (redir) begin
                        pend_pc_d = target;
                        state_d   = S_PEND;
                        if (target_bad) begin
                            misalign_d = 1'b1;
                        end
                    end
                end else if (redir) begin
                    next_pc  = target;
                    pc_hold  = 1'b0;
                    if_flush = 1'b1;
                    count_en = 1'b1;
                    if (target_bad) begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    next_pc     = pc_cur + PC_STEP;
                    pc_hold     = 1'b0;
                    fetch_valid = 1'b1;
                    count_en    = 1'b1;
                end
            end
            S_PEND: begin
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (!ID_stall) begin
                    next_pc  = pend_pc_q;
                    pc_hold  = 1'b0;
                    if_flush = 1'b1;
                    count_en = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status register next values: halted flag and saturating fetch counter.
    always_comb begin
        halted_d = (state_d == S_HALTED);
        if (count_en && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            pend_pc_q     <= '0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_pc_q     <= pend_pc_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign halted       = halted_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: a flag-based reference model and a
// model of the core PC register produce expected outputs each cycle; a
// separate monitor pops and compares them on the falling clock edge.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [31:0] pc_cur;
    logic        ID_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        halt_req;
    logic [31:0] next_pc;
    logic        pc_hold;
    logic        if_flush;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    pc_fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .PC_STEP (PC_STEP)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .pc_cur      (pc_cur),
        .ID_stall    (ID_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .halt_req    (halt_req),
        .next_pc     (next_pc),
        .pc_hold     (pc_hold),
        .if_flush    (if_flush),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .misalign_err(misalign_err),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic [31:0] nxt;
        logic        chk_nxt;
        logic        hold;
        logic        flush;
        logic        fv;
        logic        hlt;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (flags rather than a state encoding)
    bit          m_started, m_boot, m_halt, m_pend, m_mis;
    logic [31:0] m_paddr;
    logic [31:0] m_cnt;
    logic [31:0] pc_reg;
    bit          last_hold;
    logic [31:0] last_next;

    // Free-running clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the scoreboard
    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pc_hold", {31'd0, pc_hold}, {31'd0, e.hold});
            chk("if_flush", {31'd0, if_flush}, {31'd0, e.flush});
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
            chk("halted", {31'd0, halted}, {31'd0, e.hlt});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            chk("fetch_count", fetch_count, e.cnt);
            if (e.chk_nxt) chk("next_pc", next_pc, e.nxt);
        end
    end

    task automatic model_reset();
        m_started = 0; m_boot = 0; m_halt = 0; m_pend = 0; m_mis = 0;
        m_paddr = '0; m_cnt = '0;
    endtask

    task automatic bump();
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    // Expected outputs for the current cycle, then advance the model to the next edge
    task automatic model_step(input bit rst, input bit st, input bit stall, input bit br,
                              input logic [31:0] bt, input bit jv, input logic [31:0] jt,
                              input bit hr, output exp_t e);
        logic [31:0] tgt;
        bit redir, bad;
        if (!rst) model_reset();
        e.hlt = m_halt; e.mis = m_mis; e.cnt = m_cnt;
        e.nxt = pc_reg; e.chk_nxt = 0; e.hold = 1; e.flush = 0; e.fv = 0;
        tgt   = br ? bt : jt;
        redir = br | jv;
        bad   = redir && (tgt[1:0] != 2'b00);
        tgt[1:0] = 2'b00;
        if (!rst) begin
            e.nxt = RESET_PC; e.chk_nxt = 1;
        end else if (!m_started) begin
            e.nxt = RESET_PC; e.chk_nxt = 1;
            if (st) begin m_started = 1; m_boot = 1; end
        end else if (m_boot) begin
            e.nxt = RESET_PC; e.chk_nxt = 1; e.hold = 0;
            m_boot = 0;
        end else if (m_halt) begin
            // stopped until reset
        end else if (hr) begin
            m_halt = 1; m_pend = 0;
        end else if (stall) begin
            if (redir && !m_pend) begin
                m_pend = 1; m_paddr = tgt;
                if (bad) m_mis = 1;
            end
        end else if (m_pend) begin
            e.nxt = m_paddr; e.chk_nxt = 1; e.hold = 0; e.flush = 1;
            m_pend = 0; bump();
        end else if (redir) begin
            e.nxt = tgt; e.chk_nxt = 1; e.hold = 0; e.flush = 1;
            if (bad) m_mis = 1;
            bump();
        end else begin
            e.nxt = pc_reg + PC_STEP; e.chk_nxt = 1; e.hold = 0; e.fv = 1;
            bump();
        end
        last_hold = e.hold;
        last_next = e.nxt;
    endtask

    // One clock cycle of stimulus; the bench also plays the core's PC register
    task automatic cyc(input bit rst = 1, input bit st = 0, input bit stall = 0,
                       input bit br = 0, input logic [31:0] bt = '0,
                       input bit jv = 0, input logic [31:0] jt = '0,
                       input bit hr = 0, input bit fpc_en = 0, input logic [31:0] fpc = '0);
        exp_t e;
        @(posedge Clk);
        if (!last_hold) pc_reg = last_next;
        #1;
        if (fpc_en) pc_reg = fpc;
        Reset      = rst;
        start      = st;
        ID_stall   = stall;
        br_taken   = br;
        br_target  = bt;
        jmp_valid  = jv;
        jmp_target = jt;
        halt_req   = hr;
        pc_cur     = pc_reg;
        model_step(rst, st, stall, br, bt, jv, jt, hr, e);
        sb.push_back(e);
    endtask

    initial begin
        Reset = 1'b0; start = 0; pc_cur = '0; ID_stall = 0; br_taken = 0;
        br_target = '0; jmp_valid = 0; jmp_target = '0; halt_req = 0;
        pc_reg = 32'hDEAD_BEE0; last_hold = 1; last_next = '0;
        model_reset();

        // Reset, start at cycle 3, boot, three sequential fetches
        repeat (3) cyc(0);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 1);
        cyc();
        repeat (3) cyc();
        // Taken branch from 0x40 to 0x100 (fetch_count of 3 visible here)
        cyc(1, 0, 0, 1, 32'h100, 0, '0, 0, 1, 32'h40);
        // Jump held across a 3-cycle stall
        repeat (3) cyc(1, 0, 1, 0, '0, 1, 32'h200);
        cyc();
        cyc();
        // Branch and jump together, misaligned branch target
        cyc(1, 0, 0, 1, 32'h102, 1, 32'h90);
        cyc();
        cyc();
        // Halt while a redirect is pending
        cyc(1, 0, 1, 1, 32'h300);
        cyc(1, 0, 0, 0, '0, 0, '0, 1);
        repeat (3) cyc(1, 0, 0, 1, 32'h300);
        // Sequential wrap at the top of the address space
        repeat (2) cyc(0);
        cyc(1, 1);
        cyc();
        cyc(1, 0, 0, 0, '0, 0, '0, 0, 1, 32'hFFFF_FFFC);
        cyc();
        // Asynchronous reset in the middle of a pending redirect
        cyc(1, 0, 1, 0, '0, 1, 32'h400);
        cyc(1, 0, 1, 1, 32'h500);
        cyc(0, 1, 0, 1, 32'h500);
        cyc(0);
        cyc(1, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, s, stl, b, j, h;
            logic [31:0] bt, jt;
            r   = ($urandom_range(0, 149) != 0);
            s   = ($urandom_range(0, 1) == 1);
            stl = ($urandom_range(0, 9) < 3);
            b   = ($urandom_range(0, 99) < 15);
            j   = ($urandom_range(0, 99) < 12);
            h   = ($urandom_range(0, 59) == 0);
            bt  = $urandom;
            jt  = $urandom;
            if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
            cyc(r, s, stl, b, bt, j, jt, h);
        end

        cyc();
        @(negedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
